// File: rtl/rx_frame_fsm.sv
// Oversampled serial frame receiver: 1 start, 8 data (LSB first), 1 parity,
// 1 stop. Collects bits in a shadow register and publishes the whole frame
// with a one-clk ready pulse once the stop bit has been sampled.
module rx_frame_fsm #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  output logic [8:0] dataParityOut,
  output logic       ready,
  output logic       frameErr,
  output logic       busy
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } frame_t;

  logic [SYNC_STAGES-1:0] syncPipe;
  logic                   rxS;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [2:0]    idx, idxNext;
  frame_t        shadow, shadowNext;
  logic [8:0]    dpoNext;
  logic          errNext;
  logic          readyNext;
  logic          bitTick;

  // Metastability guard on the asynchronous line; idles high so reset
  // never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) syncPipe <= '1;
    else      syncPipe <= {syncPipe[SYNC_STAGES-2:0], rx};
  end

  assign rxS     = syncPipe[SYNC_STAGES-1];
  assign bitTick = tick && (cnt == CNT_END);
  assign busy    = (state != IDLE);

  // State, counters, shadow frame and the published outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shadow        <= '0;
      dataParityOut <= '0;
      frameErr      <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      idx           <= idxNext;
      shadow        <= shadowNext;
      dataParityOut <= dpoNext;
      frameErr      <= errNext;
      ready         <= readyNext;
    end
  end

  // Next-state and datapath decisions. The outputs only move on the
  // stop-sample tick, so a partial frame never becomes visible.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    idxNext    = idx;
    shadowNext = shadow;
    dpoNext    = dataParityOut;
    errNext    = frameErr;
    readyNext  = 1'b0;

    case (state)
      IDLE: begin
        cntNext = '0;
        idxNext = '0;
        if (!rxS) stateNext = START;
      end

      START: begin
        if (tick) begin
          if (cnt == CNT_MID) begin
            cntNext = '0;
            idxNext = '0;
            // Line back high at mid start bit: glitch, not a frame.
            stateNext = rxS ? IDLE : DATA;
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
      end

      DATA: begin
        if (bitTick) begin
          cntNext                 = '0;
          shadowNext.data[idx]    = rxS;
          if (idx == 3'd7) stateNext = PARITY;
          else             idxNext   = idx + 3'd1;
        end else if (tick) begin
          cntNext = cnt + CW'(1);
        end
      end

      PARITY: begin
        if (bitTick) begin
          cntNext           = '0;
          shadowNext.parity = rxS;
          stateNext         = STOP;
        end else if (tick) begin
          cntNext = cnt + CW'(1);
        end
      end

      STOP: begin
        if (bitTick) begin
          cntNext   = '0;
          dpoNext   = shadow;
          errNext   = ~rxS;
          readyNext = 1'b1;
          // A low stop bit means the line may be held in break; wait it out.
          stateNext = rxS ? IDLE : BREAK;
        end else if (tick) begin
          cntNext = cnt + CW'(1);
        end
      end

      BREAK: begin
        cntNext = '0;
        if (rxS) stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
        cntNext   = '0;
        idxNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Directed bench for rx_frame_fsm: table of complete frames plus
// hand-written false-start, break, reset, stall and back-to-back sequences.
module tb_rx_frame_fsm;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [8:0] dataParityOut;
  logic       ready, frameErr, busy;

  int passed = 0;
  int total  = 0;

  rx_frame_fsm #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx),
    .dataParityOut(dataParityOut), .ready(ready),
    .frameErr(frameErr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Ready pulse monitor: counts pulses, records frames, flags long pulses
  // and any output change that is not accompanied by ready.
  int         readyCnt = 0;
  int         readyLong = 0;
  int         glitch = 0;
  logic [8:0] capQ[$];
  logic       prevReady = 1'b0;
  logic       prevRst = 1'b0;
  logic [8:0] prevDpo = '0;
  logic       prevErr = 1'b0;

  always @(negedge clk) begin
    if (ready) begin
      readyCnt++;
      capQ.push_back(dataParityOut);
      if (prevReady) readyLong++;
    end
    if (rst && prevRst && !ready &&
        (dataParityOut != prevDpo || frameErr != prevErr)) glitch++;
    prevReady = ready;
    prevRst   = rst;
    prevDpo   = dataParityOut;
    prevErr   = frameErr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic doTick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (OS) doTick();
  endtask

  // Full frame; stallBit >= 0 freezes ticks for 100 clks mid that bit
  // (0..7 data, 8 parity) and checks that nothing visible moves.
  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s,
                           input int stallBit);
    logic [9:0] bits;
    logic [8:0] dpoBefore;
    int         rcBefore;
    bits = {p, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (stallBit >= 0 && i == stallBit + 1) begin
        rx = bits[i];
        repeat (OS / 2) doTick();
        dpoBefore = dataParityOut;
        rcBefore  = readyCnt;
        repeat (100) @(negedge clk);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_dpo", {23'd0, dataParityOut}, {23'd0, dpoBefore});
        chk("stall_noready", readyCnt, rcBefore);
        repeat (OS - OS / 2) doTick();
      end else begin
        sendBit(bits[i]);
      end
    end
    sendBit(s);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [8:0] expDpo;
    logic       expErr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rc;
    int qn;
    logic [8:0] keep;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 9'h0A5, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 9'h000, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 9'h1FF, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 9'h181, 1'b0};
    vecs[4] = '{8'h6E, 1'b0, 1'b0, 9'h06E, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_dpo", {23'd0, dataParityOut}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_ferr", {31'd0, frameErr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Table of complete frames.
    for (int v = 0; v < 5; v++) begin
      rc = readyCnt;
      sendFrame(vecs[v].d, vecs[v].p, vecs[v].s, -1);
      chk($sformatf("vec%0d_dpo", v), {23'd0, dataParityOut}, {23'd0, vecs[v].expDpo});
      chk($sformatf("vec%0d_ferr", v), {31'd0, frameErr}, {31'd0, vecs[v].expErr});
      chk($sformatf("vec%0d_ready", v), readyCnt - rc, 32'd1);
      rx = 1'b1;
      repeat (4) doTick();
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end

    // False start: line low for 4 ticks only.
    rc = readyCnt;
    keep = dataParityOut;
    rx = 1'b0;
    repeat (4) doTick();
    rx = 1'b1;
    repeat (12) doTick();
    chk("false_busy", {31'd0, busy}, 32'd0);
    chk("false_ready", readyCnt - rc, 32'd0);
    chk("false_dpo", {23'd0, dataParityOut}, {23'd0, keep});

    // Break: stop bit low, line held low 40 more ticks.
    rc = readyCnt;
    sendFrame(8'h3C, 1'b1, 1'b0, -1);
    rx = 1'b0;
    repeat (40) doTick();
    chk("brk_dpo", {23'd0, dataParityOut}, 32'h13C);
    chk("brk_ferr", {31'd0, frameErr}, 32'd1);
    chk("brk_ready", readyCnt - rc, 32'd1);
    chk("brk_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (4) doTick();
    chk("brk_exit_busy", {31'd0, busy}, 32'd0);
    chk("brk_exit_ready", readyCnt - rc, 32'd1);

    // Reset mid-frame during data bit 3.
    rc = readyCnt;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    rx = 1'b1;
    repeat (4) doTick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mid_rst_dpo", {23'd0, dataParityOut}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frameErr}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) doTick();
    chk("post_rst_noready", readyCnt - rc, 32'd0);
    sendFrame(8'h5A, 1'b1, 1'b1, -1);
    chk("post_rst_dpo", {23'd0, dataParityOut}, 32'h15A);
    chk("post_rst_ready", readyCnt - rc, 32'd1);

    // Back-to-back frames, no idle gap.
    rc = readyCnt;
    qn = capQ.size();
    sendFrame(8'h01, 1'b1, 1'b1, -1);
    sendFrame(8'hFF, 1'b0, 1'b1, -1);
    chk("b2b_ready", readyCnt - rc, 32'd2);
    if (capQ.size() >= qn + 2) begin
      chk("b2b_first", {23'd0, capQ[qn]}, 32'h101);
      chk("b2b_second", {23'd0, capQ[qn + 1]}, 32'h0FF);
    end else begin
      chk("b2b_captures", capQ.size() - qn, 32'd2);
    end

    // Tick stall mid data bit 4.
    rc = readyCnt;
    sendFrame(8'hC3, 1'b1, 1'b1, 4);
    chk("stall_end_dpo", {23'd0, dataParityOut}, 32'h1C3);
    chk("stall_end_ready", readyCnt - rc, 32'd1);
    chk("stall_end_ferr", {31'd0, frameErr}, 32'd0);

    // Pulse width and output stability across the whole run.
    repeat (4) doTick();
    chk("ready_width", readyLong, 32'd0);
    chk("dpo_stable", glitch, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rx_frame_fsm.md
RX_FRAME_FSM -- requirements
Module: rx_frame_fsm

Interface
Parameters:
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baud-tick strobes per serial bit (even, >=4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops in the rx input synchronizer (>=2).

Ports:
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick  input  1  single-clk strobe at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port dataParityOut  output  9  received frame: [7:0] data (bit 0 first on the line), [8] received parity bit.
REQ-008 SHALL have port ready  output  1  one-clk pulse marking a completed frame; downstream parity checker latches on its falling edge.
REQ-009 SHALL have port frameErr  output  1  stop bit of the last completed frame sampled low.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through SYNC_STAGES flops; all FSM decisions use the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 SHALL maintain tick counter cnt (0..OVERSAMPLE-1) and bit index idx (0..7); both advance only on tick=1.
- IDLE: on a clk with rx_s=0, go to START and clear cnt.
- START: when cnt reaches OVERSAMPLE/2-1 on a tick (mid start bit), sample rx_s. If 1: false start, return to IDLE, no ready. If 0: go to DATA, clear cnt and idx.
- DATA: on every OVERSAMPLE-th tick, sample rx_s into data bit idx (LSB first). After idx=7, go to PARITY.
- PARITY: on the next OVERSAMPLE-th tick, sample rx_s into bit 8, then go to STOP.
- STOP: on the next OVERSAMPLE-th tick, sample rx_s as the stop bit.
  - Stop bit 1: go to IDLE.
  - Stop bit 0: go to BREAK.
- BREAK: remain until rx_s=1, then go to IDLE; no frame detection while in BREAK.
REQ-014 SHALL, in the clk cycle after the stop-sample tick, update dataParityOut and frameErr together and assert ready for exactly one clk.
REQ-015 SHALL hold dataParityOut and frameErr stable from that update until the next frame completes; they SHALL not change during or after the ready pulse.
REQ-016 SHALL use a shadow register for the bits collected mid-frame; dataParityOut SHALL never show a partial frame.
REQ-017 SHALL make ready and busy mutually consistent: ready asserts in the same cycle the FSM leaves STOP.
REQ-018 SHALL ignore tick while in IDLE or BREAK; cnt is held at 0 there.
REQ-019 SHALL perform no parity evaluation; parity checking is the downstream checker's job.
REQ-020 SHALL accept a start edge in the first cycle after returning to IDLE, supporting back-to-back frames with no idle gap.

Reset
REQ-021 SHALL, while rst=0, force:
- FSM to IDLE, cnt=0, idx=0;
- dataParityOut=9'h000, ready=0, frameErr=0, busy=0;
- synchronizer flops to 1.
REQ-022 SHALL, on rst assertion mid-frame, discard the partial frame with no ready pulse; after rst deassertion the block waits for a fresh falling edge.

Verification
REQ-023 SHALL pass: frame 0xA5 with parity bit 0 and stop bit 1 at OVERSAMPLE=16 -> one ready pulse, dataParityOut=9'h0A5, frameErr=0, busy low afterwards.
REQ-024 SHALL pass: rx low for 4 ticks then high -> returns to IDLE, no ready, dataParityOut unchanged.
REQ-025 SHALL pass: frame 0x3C with parity bit 1 and stop bit 0, rx held low for 40 more ticks -> ready pulse, dataParityOut=9'h13C, frameErr=1; no new frame starts until rx returns high.
REQ-026 SHALL pass: rst asserted during DATA at idx=3 -> all outputs 0 immediately; next frame 0x5A with parity bit 1 -> dataParityOut=9'h15A, exactly one ready pulse.
REQ-027 SHALL pass: back-to-back frames 0x01 (parity 1) then 0xFF (parity 0) with no idle gap -> two ready pulses, values 9'h101 then 9'h0FF.
REQ-028 SHALL pass: tick held low mid-frame for 100 clks -> FSM stalls, no output change; frame completes correctly once ticks resume.
